// File: rtl/fifo_serial_drain_if.sv
// FIFO read port plus one-bit serial link seen by the drain.
// master = the drain (fifo_serial_drain); slave = FIFO model / serial sink.
interface fifo_serial_drain_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic                  sout;
  logic                  sframe;
  logic                  sready;

  modport master (
    output fifo_rd_en, sout, sframe,
    input  fifo_dout, fifo_empty, fifo_underflow, sready
  );

  modport slave (
    input  fifo_rd_en, sout, sframe,
    output fifo_dout, fifo_empty, fifo_underflow, sready
  );
endinterface

// File: rtl/fifo_serial_drain.sv
// Pops words from a sync FIFO and shifts them out MSB-first with frame strobe/backpressure.
// Define DRAIN_PARITY_EN to append an even-parity bit after the LSB of every frame.
module fifo_serial_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 drain_en,
  fifo_serial_drain_if.master  bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_sent,
  output logic                 err_underflow
);

`ifdef DRAIN_PARITY_EN
  localparam int FRAME_BITS = FIFO_WIDTH + 1;
`else
  localparam int FRAME_BITS = FIFO_WIDTH;
`endif
  localparam int BW       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, REQ, LOAD, SHIFT, GAP} state_t;

  state_t                state_reg, state_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [GW-1:0]         gap_reg, gap_next;
  logic [CNT_WIDTH-1:0]  words_reg, words_next;
  logic                  err_reg, err_next;
  logic [FRAME_BITS-1:0] load_word;
  logic                  can_start;

`ifdef DRAIN_PARITY_EN
  assign load_word = {bus.fifo_dout, ^bus.fifo_dout};
`else
  assign load_word = bus.fifo_dout;
`endif

  assign can_start = drain_en && !bus.fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
      gap_reg   <= '0;
      words_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      gap_reg   <= gap_next;
      words_reg <= words_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    gap_next   = gap_reg;
    words_next = words_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (can_start) state_next = REQ;
      end
      REQ: begin
        state_next = LOAD;
      end
      LOAD: begin
        // An underflowed pop carries no data: drop the frame but keep the gap.
        if (bus.fifo_underflow) begin
          err_next   = 1'b1;
          gap_next   = GW'(GAP_LAST);
          state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          shift_next = load_word;
          bit_next   = BW'(FRAME_BITS - 1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sready) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
          bit_next   = bit_reg - 1'b1;
          if (bit_reg == '0) begin
            words_next = words_reg + 1'b1;
            gap_next   = GW'(GAP_LAST);
            state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        if (gap_reg == '0) state_next = can_start ? REQ : IDLE;
        else               gap_next   = gap_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.fifo_rd_en = (state_reg == REQ);
  assign bus.sframe     = (state_reg == SHIFT);
  assign bus.sout       = (state_reg == SHIFT) && shift_reg[FRAME_BITS-1];
  assign busy           = (state_reg != IDLE);
  assign words_sent     = words_reg;
  assign err_underflow  = err_reg;

endmodule
